// File: rtl/fast_cmd_word_aligner_if.sv
// Fast-command aligner bus: serial input side and recovered-word side.
// The aligner itself is the slave; the bit-stream source is the master.
interface fast_cmd_word_aligner_if #(
  parameter int WORD_W   = 8,
  parameter int ERRCNT_W = 8
);
  logic                fc;
  logic                realign;
  logic                aligned;
  logic [WORD_W-1:0]   fcd;
  logic                fcdValid;
  logic                invalidCmd;
  logic [3:0]          slipCnt;
  logic [ERRCNT_W-1:0] errCnt;

  modport master (
    output fc, realign,
    input  aligned, fcd, fcdValid,
    input  invalidCmd, slipCnt, errCnt
  );

  modport slave (
    input  fc, realign,
    output aligned, fcd, fcdValid,
    output invalidCmd, slipCnt, errCnt
  );
endinterface

// File: rtl/fast_cmd_word_aligner.sv
// Serial fast-command word aligner: slips one bit at a time until
// IDLE_WORD repeats LOCK_THR times, then frames and checks balanced words.
module fast_cmd_word_aligner #(
  parameter int                WORD_W     = 8,
  parameter logic [WORD_W-1:0] IDLE_WORD  = 8'hF0,
  parameter int                LOCK_THR   = 4,
  parameter int                UNLOCK_THR = 3,
  parameter int                ERRCNT_W   = 8
) (
  input  logic                     clk320,
  input  logic                     rstn,
  fast_cmd_word_aligner_if.slave   bus
);

  localparam int PH_W = $clog2(WORD_W);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(WORD_W - 1);

  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]          r_state;
  logic [PH_W-1:0]     r_ph;
  logic [WORD_W-2:0]   r_sr;
  logic [3:0]          r_good;
  logic [3:0]          r_bad;
  logic [3:0]          r_slip;
  logic [ERRCNT_W-1:0] r_err;
  logic [WORD_W-1:0]   r_fcd;
  logic                r_fcd_vld;
  logic                r_inv;

  logic [WORD_W-1:0]   w_word;
  logic                w_bnd;
  logic                w_idle;
  logic                w_valid;
  logic                w_srch;
  logic [3:0]          w_good_nxt;
  logic [3:0]          w_bad_nxt;
  logic                w_lock_hit;
  logic                w_unlock_hit;

  function automatic logic f_balanced(
    input logic [WORD_W-1:0] w
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < WORD_W; i++)
      n += 32'(w[i]);
    return n == WORD_W / 2;
  endfunction

  assign w_word       = {r_sr, bus.fc};
  assign w_bnd        = (r_ph == PH_LAST);
  assign w_idle       = (w_word == IDLE_WORD);
  assign w_valid      = f_balanced(w_word);
  assign w_srch       = (r_state == S_SEARCH);
  assign w_good_nxt   = r_good + 4'd1;
  assign w_bad_nxt    = r_bad + 4'd1;
  assign w_lock_hit   = (w_good_nxt == 4'(LOCK_THR));
  assign w_unlock_hit = (w_bad_nxt == 4'(UNLOCK_THR));

  always_ff @(posedge clk320 or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_SEARCH;
      r_ph      <= '0;
      r_sr      <= '0;
      r_good    <= '0;
      r_bad     <= '0;
      r_slip    <= '0;
      r_err     <= '0;
      r_fcd     <= '0;
      r_fcd_vld <= 1'b0;
      r_inv     <= 1'b0;
    end else begin
      r_sr      <= {r_sr[WORD_W-3:0], bus.fc};
      r_fcd_vld <= 1'b0;
      r_inv     <= 1'b0;
      if (bus.realign) begin
        r_state <= S_SEARCH;
        r_ph    <= '0;
        r_good  <= '0;
        r_bad   <= '0;
        r_slip  <= '0;
        r_err   <= '0;
      end else begin
        unique case (1'b1)
          !w_bnd: begin
            r_ph <= r_ph + 1'b1;
          end
          w_bnd && w_srch && w_idle: begin
            r_ph <= '0;
            if (w_lock_hit) begin
              r_state <= S_LOCKED;
              r_good  <= '0;
            end else begin
              r_good  <= w_good_nxt;
            end
          end
          // ph held at the boundary: next bit is tried as a new word end
          w_bnd && w_srch && !w_idle: begin
            r_good <= '0;
            if (r_slip != 4'hF)
              r_slip <= r_slip + 4'd1;
          end
          w_bnd && !w_srch: begin
            r_ph      <= '0;
            r_fcd     <= w_word;
            r_fcd_vld <= 1'b1;
            if (!w_valid) begin
              r_inv <= 1'b1;
              if (r_err != '1)
                r_err <= r_err + ERRCNT_W'(1);
              if (w_unlock_hit) begin
                r_state <= S_SEARCH;
                r_bad   <= '0;
                r_good  <= '0;
                r_slip  <= '0;
              end else begin
                r_bad   <= w_bad_nxt;
              end
            end else begin
              r_bad <= '0;
            end
          end
        endcase
      end
    end
  end

  assign bus.aligned    = (r_state == S_LOCKED);
  assign bus.fcd        = r_fcd;
  assign bus.fcdValid   = r_fcd_vld;
  assign bus.invalidCmd = r_inv;
  assign bus.slipCnt    = r_slip;
  assign bus.errCnt     = r_err;

endmodule

// File: tb/tb_fast_cmd_word_aligner.sv
// Bench for fast_cmd_word_aligner: random and directed bit streams
// against a word-level reference model, two error-counter widths.
module tb_fast_cmd_word_aligner;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  fast_cmd_word_aligner_if #(.WORD_W(8), .ERRCNT_W(8)) ifa ();
  fast_cmd_word_aligner_if #(.WORD_W(8), .ERRCNT_W(2)) ifb ();

  assign ifb.fc      = ifa.fc;
  assign ifb.realign = ifa.realign;

  fast_cmd_word_aligner #(.ERRCNT_W(8)) u_a (
    .clk320 (clk),
    .rstn   (rstn),
    .bus    (ifa)
  );

  fast_cmd_word_aligner #(.ERRCNT_W(2)) u_b (
    .clk320 (clk),
    .rstn   (rstn),
    .bus    (ifb)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: m_need = bits still to arrive before the next word decision
  int m_hist, m_need, m_good, m_bad, m_slip, m_err, m_err2, m_fcd;
  bit m_locked, m_vld, m_inv;

  task automatic m_reset();
    m_hist = 0; m_need = 8; m_good = 0; m_bad = 0;
    m_slip = 0; m_err = 0; m_err2 = 0; m_fcd = 0;
    m_locked = 0; m_vld = 0; m_inv = 0;
  endtask

  task automatic m_step(bit b, bit ra);
    int word;
    m_hist = ((m_hist * 2) + int'(b)) % 256;
    word   = m_hist;
    m_vld  = 0;
    m_inv  = 0;
    if (ra) begin
      m_locked = 0; m_need = 8;
      m_good = 0; m_bad = 0; m_slip = 0; m_err = 0; m_err2 = 0;
    end else if (m_need > 1) begin
      m_need--;
    end else if (!m_locked) begin
      if (word == 'hF0) begin
        m_need = 8;
        m_good++;
        if (m_good == 4) begin
          m_locked = 1;
          m_good = 0;
        end
      end else begin
        m_need = 1;
        m_good = 0;
        if (m_slip < 15) m_slip++;
      end
    end else begin
      m_fcd  = word;
      m_vld  = 1;
      m_need = 8;
      if ($countones(word[7:0]) != 4) begin
        m_inv = 1;
        if (m_err < 255) m_err++;
        if (m_err2 < 3) m_err2++;
        m_bad++;
        if (m_bad == 3) begin
          m_locked = 0; m_bad = 0; m_good = 0; m_slip = 0;
        end
      end else begin
        m_bad = 0;
      end
    end
  endtask

  task automatic cyc(bit b, bit ra);
    ifa.fc      = b;
    ifa.realign = ra;
    @(posedge clk);
    m_step(b, ra);
    #1;
    chk("c_aligned", 32'(ifa.aligned), 32'(m_locked));
    chk("c_fcd", 32'(ifa.fcd), 32'(m_fcd));
    chk("c_fcdValid", 32'(ifa.fcdValid), 32'(m_vld));
    chk("c_invalid", 32'(ifa.invalidCmd), 32'(m_inv));
    chk("c_slipCnt", 32'(ifa.slipCnt), 32'(m_slip));
    chk("c_errCnt", 32'(ifa.errCnt), 32'(m_err));
    chk("c_errCnt2", 32'(ifb.errCnt), 32'(m_err2));
  endtask

  task automatic send_word(logic [7:0] w, int ra_bit);
    for (int i = 7; i >= 0; i--)
      cyc(w[i], i == ra_bit);
  endtask

  task automatic lock_idle(string tag);
    for (int n = 0; n < 24 && !ifa.aligned; n++)
      send_word(8'hF0, -1);
    chk(tag, 32'(ifa.aligned), 32'd1);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_al"}, 32'(ifa.aligned), 0);
    chk({tag, "_fcd"}, 32'(ifa.fcd), 0);
    chk({tag, "_vld"}, 32'(ifa.fcdValid), 0);
    chk({tag, "_inv"}, 32'(ifa.invalidCmd), 0);
    chk({tag, "_slip"}, 32'(ifa.slipCnt), 0);
    chk({tag, "_err"}, 32'(ifa.errCnt), 0);
    chk({tag, "_err2"}, 32'(ifb.errCnt), 0);
  endtask

  initial begin
    logic [7:0] w;
    int ra;
    rstn        = 1'b0;
    ifa.fc      = 1'b0;
    ifa.realign = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    rstn = 1'b1;

    // idle stream at every bit offset
    for (int k = 0; k < 8; k++) begin
      cyc(1'($urandom_range(0, 1)), 1'b1);
      for (int j = 0; j < k; j++)
        cyc(1'($urandom_range(0, 1)), 1'b0);
      lock_idle("off_lock");
      chk("off_slips", 32'(ifa.slipCnt), 32'(k));
      chk("off_fcd", 32'(ifa.fcd), 32'h00);
    end

    send_word(8'h3C, -1);
    chk("w3c_fcd", 32'(ifa.fcd), 32'h3C);
    chk("w3c_vld", 32'(ifa.fcdValid), 1);
    send_word(8'h99, -1);
    chk("w99_fcd", 32'(ifa.fcd), 32'h99);
    chk("w99_inv", 32'(ifa.invalidCmd), 0);
    chk("w99_err", 32'(ifa.errCnt), 0);

    send_word(8'hFF, -1);
    chk("bad1_inv", 32'(ifa.invalidCmd), 1);
    send_word(8'h01, -1);
    chk("bad2_al", 32'(ifa.aligned), 1);
    send_word(8'h00, -1);
    chk("bad3_al", 32'(ifa.aligned), 0);
    chk("bad3_err", 32'(ifa.errCnt), 3);
    chk("bad3_fcd", 32'(ifa.fcd), 32'h00);

    cyc(1'b0, 1'b1);
    lock_idle("relock");
    send_word(8'hFF, -1);
    send_word(8'h00, -1);
    send_word(8'h3C, -1);
    send_word(8'hFF, -1);
    chk("ivvi_al", 32'(ifa.aligned), 1);
    chk("ivvi_err", 32'(ifa.errCnt), 3);

    cyc(1'b1, 1'b1);
    for (int n = 0; n < 3; n++)
      send_word(8'hF0, -1);
    send_word(8'hF0, 0);
    chk("ra4_al", 32'(ifa.aligned), 0);
    chk("ra4_slip", 32'(ifa.slipCnt), 0);
    chk("ra4_err", 32'(ifa.errCnt), 0);
    lock_idle("ra4_relock");

    for (int n = 0; n < 5; n++) begin
      send_word(8'hFF, -1);
      send_word(8'h3C, -1);
    end
    chk("sat_err2", 32'(ifb.errCnt), 3);
    chk("sat_err8", 32'(ifa.errCnt), 5);
    chk("sat_al", 32'(ifa.aligned), 1);

    for (int i = 0; i < 3; i++)
      cyc(1'($urandom_range(0, 1)), 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    m_reset();
    chk_all_zero("arst");
    @(posedge clk);
    #1;
    chk_all_zero("arst_hold");
    rstn = 1'b1;

    for (int n = 0; n < 400; n++) begin
      if (m_locked)
        w = ($urandom_range(0, 9) < 2) ? 8'hF0 : 8'($urandom_range(0, 255));
      else
        w = ($urandom_range(0, 9) < 7) ? 8'hF0 : 8'($urandom_range(0, 255));
      ra = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 7)) : -1;
      send_word(w, ra);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fast_cmd_word_aligner.md
FAST_CMD_WORD_ALIGNER -- requirements
Module: fast_cmd_word_aligner

Interface
REQ-001 Parameter WORD_W, default 8, fast-command word width in bits; even, >= 4.
REQ-002 Parameter IDLE_WORD, default 8'hF0, alignment pattern, WORD_W bits; no non-trivial rotation of it equals itself.
REQ-003 Parameter LOCK_THR, default 4, consecutive IDLE words needed to lock; range 1..15.
REQ-004 Parameter UNLOCK_THR, default 3, consecutive invalid words needed to drop lock; range 1..15.
REQ-005 Parameter ERRCNT_W, default 8, width of the invalid-word error counter.
REQ-006 clk320  input  1  320 MHz bit clock; fc is sampled on its rising edge; the block's only clock.
REQ-007 rstn  input  1  reset; asynchronous assertion, active low.
REQ-008 fc  input  1  serial fast-command bit stream, MSB first.
REQ-009 realign  input  1  synchronous pulse; forces a new alignment search.
REQ-010 aligned  output  1  high while in LOCKED.
REQ-011 fcd  output  WORD_W  last word captured while LOCKED.
REQ-012 fcdValid  output  1  one-cycle strobe; fcd updated this cycle.
REQ-013 invalidCmd  output  1  one-cycle strobe; word captured in LOCKED was invalid.
REQ-014 slipCnt  output  4  saturating count of bit slips since the last search start.
REQ-015 errCnt  output  ERRCNT_W  saturating count of invalid words since reset/realign.

Function
REQ-016 A shift register sr of WORD_W-1 bits SHALL shift left every cycle with fc entering the LSB; candidate word w = {sr, fc}.
REQ-017 Phase counter ph (0..WORD_W-1) SHALL increment every cycle; a boundary cycle is one with ph == WORD_W-1.
REQ-018 A word SHALL be valid iff its popcount equals WORD_W/2.
REQ-019 States SHALL be SEARCH, LOCKED; reset state SEARCH.
REQ-020 SEARCH, boundary, w == IDLE_WORD: ph <= 0, goodCnt++; goodCnt reaching LOCK_THR -> LOCKED, goodCnt <= 0.
REQ-021 SEARCH, boundary, w != IDLE_WORD: ph stays WORD_W-1 (one-bit slip; next cycle is again a boundary), goodCnt <= 0, slipCnt++ saturating at 15.
REQ-022 LOCKED, boundary: fcd <= w, fcdValid pulses the following cycle; ph wraps to 0 (no slips in LOCKED).
REQ-023 LOCKED, boundary, w invalid: invalidCmd pulses together with fcdValid, badCnt++, errCnt++ saturating at all-ones; w valid: badCnt <= 0.
REQ-024 badCnt reaching UNLOCK_THR SHALL cause SEARCH on the same edge: aligned drops, badCnt and goodCnt cleared, slipCnt cleared; fcd holds its last value.
REQ-025 In SEARCH, fcdValid and invalidCmd SHALL remain 0 and fcd SHALL hold.
REQ-026 realign = 1 SHALL, on that edge, force SEARCH, ph <= 0, clear goodCnt, badCnt, slipCnt, errCnt; realign wins over any simultaneous lock, unlock or boundary event, and no strobe is issued that cycle.
REQ-027 aligned SHALL be a registered state decode; it rises on the edge the LOCK_THR-th IDLE word is accepted.
REQ-028 IDLE_WORD received in LOCKED SHALL be treated as a normal valid word (captured and strobed).

Reset
REQ-029 rstn low SHALL asynchronously set state SEARCH, ph = 0, sr = 0, goodCnt = badCnt = 0, aligned = 0, fcd = 0, fcdValid = 0, invalidCmd = 0, slipCnt = 0, errCnt = 0.
REQ-030 Reset release SHALL take effect on the first clk320 rising edge with rstn high; reset asserted mid-word or mid-lock discards all progress.

Verification
REQ-031 Defaults, repeated 0xF0 stream at arbitrary bit offset k (0..7) -> aligned rises after <= 7 slips plus 4 words; slipCnt == required slip count; fcd stays 0x00.
REQ-032 Locked, send 0x3C then 0x99 -> fcd = 0x3C then 0x99, one fcdValid each, invalidCmd 0, errCnt 0.
REQ-033 Locked, send 0xFF, 0x01, 0x00 consecutively -> three invalidCmd pulses, errCnt = 3, aligned drops on the third boundary edge, fcd = 0x00.
REQ-034 Locked, invalid, invalid, valid, invalid -> badCnt resets, aligned stays 1, errCnt = 3.
REQ-035 realign asserted on the same cycle as the 4th IDLE boundary -> aligned stays 0, all counters 0, search restarts.
REQ-036 ERRCNT_W = 2, 5 isolated invalid words while locked -> errCnt saturates at 3; rstn pulse mid-word -> all outputs 0 immediately, asynchronously.
